// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD write-engine scheduler and its clients:
// FSM state encoding, word format and the command opcodes the show clients emit.
package lcd_pkg;

  localparam int LCD_WORD_W = 9;
  localparam int LCD_DC_BIT = 8;

  localparam logic [LCD_WORD_W-1:0] LCD_CMD_CASET = 9'h02A;
  localparam logic [LCD_WORD_W-1:0] LCD_CMD_RASET = 9'h02B;
  localparam logic [LCD_WORD_W-1:0] LCD_CMD_RAMWR = 9'h02C;

  typedef enum logic [6:0] {
    PWR_WAIT  = 7'b000_0001,
    INIT_GO   = 7'b000_0010,
    INIT_BUSY = 7'b000_0100,
    IDLE      = 7'b000_1000,
    SHOW_GO   = 7'b001_0000,
    SHOW_BUSY = 7'b010_0000,
    GAP       = 7'b100_0000
  } lcd_state_e;

  // A word with the DC bit clear is a command, otherwise pixel/parameter data.
  function automatic logic lcd_is_cmd(input logic [LCD_WORD_W-1:0] word);
    return ~word[LCD_DC_BIT];
  endfunction

endpackage

// File: rtl/lcd_rr_pick.sv
// Combinational round-robin picker: first set pending bit at or above rr_ptr,
// wrapping at NUM_SHOW.
module lcd_rr_pick #(
  parameter int NUM_SHOW = 3
) (
  input  logic [NUM_SHOW-1:0] pending,
  input  logic [2:0]          rr_ptr,
  output logic                valid,
  output logic [2:0]          idx
);

  logic [NUM_SHOW-1:0] rot;
  logic [3:0]          sum;

  // Rotate so that bit 0 corresponds to the client at rr_ptr.
  assign rot = NUM_SHOW'({pending, pending} >> rr_ptr);

  always_comb begin
    valid = 1'b0;
    idx   = 3'd0;
    sum   = 4'd0;
    // Walk downward so the lowest rotated position wins.
    for (int k = NUM_SHOW - 1; k >= 0; k--) begin
      if (rot[k]) begin
        valid = 1'b1;
        sum   = {1'b0, rr_ptr} + 4'(k);
        if (sum >= 4'(NUM_SHOW)) begin
          sum = sum - 4'(NUM_SHOW);
        end
        idx = sum[2:0];
      end
    end
  end

endmodule

// File: rtl/lcd_show_sched.sv
// LCD write-engine scheduler: power-on delay, one init task, then round-robin show tasks.
// Optional BUSY watchdog enabled by defining LCD_SHOW_SCHED_TIMEOUT_EN.
module lcd_show_sched
  import lcd_pkg::*;
#(
  parameter int          NUM_SHOW        = 3,
  parameter logic [23:0] POWER_ON_CYCLES = 24'd5_000_000,
  parameter logic [7:0]  GAP_CYCLES      = 8'd16,
  parameter logic [23:0] TIMEOUT_CYCLES  = 24'd10_000_000
) (
  input  logic                           sys_clk,
  input  logic                           sys_rst_n,
  input  logic                           wr_done,
  output logic [LCD_WORD_W-1:0]          lcd_data,
  output logic                           lcd_en_write,
  output logic                           init_flag,
  input  logic                           init_en_write,
  input  logic [LCD_WORD_W-1:0]          init_data,
  output logic                           init_wr_done,
  input  logic                           init_done,
  input  logic [NUM_SHOW-1:0]            show_req,
  output logic [NUM_SHOW-1:0]            show_flag,
  input  logic [NUM_SHOW-1:0]            show_en_write,
  input  logic [LCD_WORD_W*NUM_SHOW-1:0] show_data,
  output logic [NUM_SHOW-1:0]            show_wr_done,
  input  logic [NUM_SHOW-1:0]            show_done,
  output logic                           init_ok,
  output logic                           busy,
  output logic [2:0]                     grant_id,
  output logic                           timeout_err
);

  if (NUM_SHOW < 2 || NUM_SHOW > 8 || POWER_ON_CYCLES == 24'd0 ||
      TIMEOUT_CYCLES == 24'd0) begin : g_cfg_err
    $error("lcd_show_sched: illegal parameter set");
  end

  lcd_state_e          state, state_nxt;
  logic [NUM_SHOW-1:0] pending, pend_clr;
  logic [2:0]          rr_ptr;
  logic [23:0]         pwr_cnt;
  logic [7:0]          gap_cnt;
  logic                pick_vld;
  logic [2:0]          pick_idx;
  logic                grant_take;
  logic                in_init, in_show, in_busy;
  logic                show_hit;
  logic                wd_trip;
  logic [7:0]          flag8;
  logic [7:0]          en8;
  logic [LCD_WORD_W-1:0] word8 [8];

  lcd_rr_pick #(
    .NUM_SHOW (NUM_SHOW)
  ) u_rr_pick (
    .pending (pending),
    .rr_ptr  (rr_ptr),
    .valid   (pick_vld),
    .idx     (pick_idx)
  );

  assign in_init    = (state == INIT_GO) || (state == INIT_BUSY);
  assign in_show    = (state == SHOW_GO) || (state == SHOW_BUSY);
  assign in_busy    = (state == INIT_BUSY) || (state == SHOW_BUSY);
  assign grant_take = (state == IDLE) && pick_vld;
  assign flag8      = 8'b1 << grant_id;
  // Only the granted client's done can end a show task.
  assign show_hit   = |(show_done & flag8[NUM_SHOW-1:0]);

`ifdef LCD_SHOW_SCHED_TIMEOUT_EN
  logic [23:0] wd_cnt;
  logic        tmo_q;

  assign wd_trip     = in_busy && !wr_done && (wd_cnt == TIMEOUT_CYCLES - 24'd1);
  assign timeout_err = tmo_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wd_cnt <= 24'd0;
      tmo_q  <= 1'b0;
    end else begin
      wd_cnt <= (!in_busy || wr_done) ? 24'd0 : wd_cnt + 24'd1;
      if (wd_trip) begin
        tmo_q <= 1'b1;
      end
    end
  end
`else
  assign wd_trip     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      PWR_WAIT:  if (pwr_cnt == POWER_ON_CYCLES - 24'd1) state_nxt = INIT_GO;
      INIT_GO:   state_nxt = INIT_BUSY;
      INIT_BUSY: if (init_done || wd_trip) state_nxt = GAP;
      IDLE:      if (pick_vld) state_nxt = SHOW_GO;
      SHOW_GO:   state_nxt = SHOW_BUSY;
      SHOW_BUSY: if (show_hit || wd_trip) state_nxt = GAP;
      GAP:       if (GAP_CYCLES == 8'd0 || gap_cnt == GAP_CYCLES - 8'd1) state_nxt = IDLE;
      default:   state_nxt = PWR_WAIT;
    endcase
  end

  always_comb begin
    pend_clr = '0;
    for (int i = 0; i < NUM_SHOW; i++) begin
      pend_clr[i] = grant_take && (pick_idx == 3'(i));
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= PWR_WAIT;
      pending  <= '0;
      rr_ptr   <= 3'd0;
      grant_id <= 3'd0;
      init_ok  <= 1'b0;
      busy     <= 1'b0;
      pwr_cnt  <= 24'd0;
      gap_cnt  <= 8'd0;
    end else begin
      state   <= state_nxt;
      // OR-ing show_req after the clear lets a same-cycle request win.
      pending <= (pending & ~pend_clr) | show_req;
      busy    <= (state_nxt != IDLE);
      pwr_cnt <= (state == PWR_WAIT) ? pwr_cnt + 24'd1 : 24'd0;
      gap_cnt <= (state == GAP) ? gap_cnt + 8'd1 : 8'd0;
      if (grant_take) begin
        grant_id <= pick_idx;
        rr_ptr   <= (pick_idx == 3'(NUM_SHOW - 1)) ? 3'd0 : pick_idx + 3'd1;
      end
      if (state == INIT_BUSY && init_done) begin
        init_ok <= 1'b1;
      end
    end
  end

  // Unpack client buses into 8-entry tables so a 3-bit grant indexes them directly.
  always_comb begin
    en8 = 8'd0;
    for (int i = 0; i < 8; i++) begin
      word8[i] = '0;
    end
    for (int i = 0; i < NUM_SHOW; i++) begin
      en8[i]   = show_en_write[i];
      word8[i] = show_data[LCD_WORD_W*i +: LCD_WORD_W];
    end
  end

  always_comb begin
    lcd_data     = '0;
    lcd_en_write = 1'b0;
    init_wr_done = 1'b0;
    show_wr_done = '0;
    if (in_init) begin
      lcd_data     = init_data;
      lcd_en_write = init_en_write;
      init_wr_done = wr_done;
    end else if (in_show) begin
      lcd_data     = word8[grant_id];
      lcd_en_write = en8[grant_id];
      show_wr_done = flag8[NUM_SHOW-1:0] & {NUM_SHOW{wr_done}};
    end
  end

  assign init_flag = (state == INIT_GO);
  assign show_flag = (state == SHOW_GO) ? flag8[NUM_SHOW-1:0] : '0;

endmodule

// File: tb/tb_lcd_show_sched.sv
// Directed bench for lcd_show_sched: init sequencing, request holding, round-robin
// order, routing, reset mid-task and BUSY watchdog behaviour.
module tb_lcd_show_sched;

  localparam int NS = 3;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n;
  logic          wr_done;
  logic [8:0]    lcd_data;
  logic          lcd_en_write;
  logic          init_flag;
  logic          init_en_write;
  logic [8:0]    init_data;
  logic          init_wr_done;
  logic          init_done;
  logic [NS-1:0] show_req;
  logic [NS-1:0] show_flag;
  logic [NS-1:0] show_en_write;
  logic [9*NS-1:0] show_data;
  logic [NS-1:0] show_wr_done;
  logic [NS-1:0] show_done;
  logic          init_ok;
  logic          busy;
  logic [2:0]    grant_id;
  logic          timeout_err;

  int checks   = 0;
  int failures = 0;
  int n_gap;

  lcd_show_sched #(
    .NUM_SHOW        (NS),
    .POWER_ON_CYCLES (24'd20),
    .GAP_CYCLES      (8'd4),
    .TIMEOUT_CYCLES  (24'd100)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .wr_done       (wr_done),
    .lcd_data      (lcd_data),
    .lcd_en_write  (lcd_en_write),
    .init_flag     (init_flag),
    .init_en_write (init_en_write),
    .init_data     (init_data),
    .init_wr_done  (init_wr_done),
    .init_done     (init_done),
    .show_req      (show_req),
    .show_flag     (show_flag),
    .show_en_write (show_en_write),
    .show_data     (show_data),
    .show_wr_done  (show_wr_done),
    .show_done     (show_done),
    .init_ok       (init_ok),
    .busy          (busy),
    .grant_id      (grant_id),
    .timeout_err   (timeout_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge sys_clk);
  endtask

  function automatic logic [8:0] word_of(input int id);
    case (id)
      0:       return 9'h02A;
      1:       return 9'h02B;
      default: return 9'h1A5;
    endcase
  endfunction

  // Count negedges from a done pulse until the next show_flag, checking the engine idles meanwhile.
  task automatic wait_flag(output int n);
    logic seen;
    seen = 1'b0;
    n    = 0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      step();
      init_done = 1'b0;
      show_done = '0;
      if (show_flag != '0) begin
        seen = 1'b1;
        n    = k;
      end else begin
        chk("gap_en_write", 32'(lcd_en_write), 32'd0);
      end
    end
  endtask

  // Called at the SHOW_GO negedge; ends at the negedge where show_done is driven.
  task automatic do_show(input int id, input bit spur);
    chk("grant_id", 32'(grant_id), 32'(id));
    chk("show_flag", 32'(show_flag), 32'd1 << id);
    chk("grant_en", 32'(lcd_en_write), 32'd1);
    chk("grant_data", 32'(lcd_data), 32'(word_of(id)));
    step();
    chk("flag_one_cycle", 32'(show_flag), 32'd0);
    if (spur) begin
      show_done = 3'b100;
      step();
      show_done = '0;
    end
    wr_done = 1'b1;
    #1;
    chk("wr_route", 32'(show_wr_done), 32'd1 << id);
    chk("wr_route_init", 32'(init_wr_done), 32'd0);
    step();
    wr_done   = 1'b0;
    show_done = NS'(1 << id);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    sys_rst_n     = 1'b0;
    wr_done       = 1'b0;
    init_en_write = 1'b0;
    init_data     = 9'h000;
    init_done     = 1'b0;
    show_req      = '0;
    show_en_write = '0;
    show_data     = {word_of(2), word_of(1), word_of(0)};
    show_done     = '0;

    repeat (3) step();
    chk("rst_lcd_data", 32'(lcd_data), 32'd0);
    chk("rst_en_write", 32'(lcd_en_write), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_flags", 32'({init_flag, show_flag}), 32'd0);
    chk("rst_init_ok", 32'(init_ok), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);

    sys_rst_n = 1'b1;
    repeat (19) step();
    chk("pwr_wait_flag", 32'(init_flag), 32'd0);
    chk("pwr_wait_busy", 32'(busy), 32'd1);
    step();
    chk("init_flag", 32'(init_flag), 32'd1);
    init_en_write = 1'b1;
    init_data     = 9'h011;
    #1;
    chk("init_word0", 32'(lcd_data), 32'h011);
    chk("init_en", 32'(lcd_en_write), 32'd1);
    step();
    chk("init_flag_pulse", 32'(init_flag), 32'd0);
    show_req = 3'b010;
    wr_done  = 1'b1;
    #1;
    chk("init_wr_done", 32'(init_wr_done), 32'd1);
    chk("init_show_wrd", 32'(show_wr_done), 32'd0);
    step();
    show_req  = '0;
    wr_done   = 1'b0;
    init_data = 9'h129;
    show_done = 3'b010;
    #1;
    chk("init_word1", 32'(lcd_data), 32'h129);
    chk("init_wr_done_lo", 32'(init_wr_done), 32'd0);
    step();
    show_done = '0;
    init_done = 1'b1;
    chk("init_ok_before", 32'(init_ok), 32'd0);
    wait_flag(n_gap);
    init_en_write = 1'b0;
    chk("init_gap_len", 32'(n_gap), 32'd6);
    chk("init_ok_set", 32'(init_ok), 32'd1);

    // Held request from client 1, then reset in the middle of its task.
    chk("held_flag", 32'(show_flag), 32'b010);
    chk("held_grant", 32'(grant_id), 32'd1);
    show_en_write = 3'b010;
    #1;
    chk("c1_data", 32'(lcd_data), 32'(word_of(1)));
    step();
    wr_done  = 1'b1;
    show_req = 3'b100;
    #1;
    chk("c1_wr_route", 32'(show_wr_done), 32'b010);
    step();
    show_req  = '0;
    sys_rst_n = 1'b0;
    #1;
    chk("mid_rst_en", 32'(lcd_en_write), 32'd0);
    chk("mid_rst_data", 32'(lcd_data), 32'd0);
    chk("mid_rst_wrd", 32'(show_wr_done), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_grant", 32'(grant_id), 32'd0);
    chk("mid_rst_init_ok", 32'(init_ok), 32'd0);
    step();
    step();
    wr_done       = 1'b0;
    show_en_write = '0;
    sys_rst_n     = 1'b1;
    repeat (19) step();
    chk("reinit_wait", 32'(init_flag), 32'd0);
    step();
    chk("reinit_flag", 32'(init_flag), 32'd1);
    step();
    init_done = 1'b1;
    step();
    init_done = 1'b0;
    repeat (4) step();
    chk("idle_busy", 32'(busy), 32'd0);
    repeat (3) step();
    chk("pend_cleared_flag", 32'(show_flag), 32'd0);
    chk("pend_cleared_busy", 32'(busy), 32'd0);

    // All three request at once with rr=0; client 0 re-requests in its grant cycle.
    show_req      = 3'b111;
    show_en_write = 3'b111;
    step();
    show_req = 3'b001;
    step();
    show_req = '0;
    do_show(0, 1'b1);
    wait_flag(n_gap);
    chk("gap_0_1", 32'(n_gap), 32'd6);
    do_show(1, 1'b0);
    wait_flag(n_gap);
    chk("gap_1_2", 32'(n_gap), 32'd6);
    do_show(2, 1'b0);
    wait_flag(n_gap);
    chk("gap_2_0", 32'(n_gap), 32'd6);
    chk("rerun_grant", 32'(grant_id), 32'd0);
    chk("rerun_flag", 32'(show_flag), 32'b001);

    // No wr_done and no show_done: watchdog behaviour in SHOW_BUSY.
    step();
    repeat (120) step();
`ifdef LCD_SHOW_SCHED_TIMEOUT_EN
    chk("timeout_err", 32'(timeout_err), 32'd1);
    chk("timeout_en", 32'(lcd_en_write), 32'd0);
    chk("timeout_idle", 32'(busy), 32'd0);
`else
    chk("no_timeout_err", 32'(timeout_err), 32'd0);
    chk("stuck_busy_en", 32'(lcd_en_write), 32'd1);
    wr_done = 1'b1;
    #1;
    chk("stuck_busy_route", 32'(show_wr_done), 32'b001);
    wr_done = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
